// File: rtl/pc_redirect_ctrl.sv
// PC redirect / flush / stall sequencer for the 5-stage RISC-V core.
// Optional macro REDIRECT_STATS_EN adds saturating taken/stall counters.
//
// Ports:
//   clk, rst_n        rising-edge clock, synchronous active-low reset
//   ex_valid          EX holds a valid instruction
//   ex_branch         EX branch resolved taken
//   ex_jump           EX holds JAL/JALR
//   ex_target         redirect target computed in EX
//   load_use_hazard   ID depends on a load in EX
//   imem_ready        instruction memory accepts a fetch
//   pc_cur            current PC register value
//   pc_we, pc_next    PC register write enable / value
//   flush_ifid        bubble into IF/ID
//   flush_idex        bubble into ID/EX
//   stall_ifid        hold IF/ID
//   redirect_busy     redirect pending or settling
//   misalign_trap     one-cycle pulse after a misaligned taken target
//   taken_cnt         redirects written to the PC (stats build only)
//   stall_cnt         cycles without a PC write (stats build only)

module pc_redirect_ctrl #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ex_valid,
   input  logic             ex_branch,
   input  logic             ex_jump,
   input  logic [XLEN-1:0]  ex_target,
   input  logic             load_use_hazard,
   input  logic             imem_ready,
   input  logic [XLEN-1:0]  pc_cur,
   output logic             pc_we,
   output logic [XLEN-1:0]  pc_next,
   output logic             flush_ifid,
   output logic             flush_idex,
   output logic             stall_ifid,
   output logic             redirect_busy,
   output logic             misalign_trap,
   output logic [CNT_W-1:0] taken_cnt,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {
      S_RUN    = 2'd0,
      S_PEND   = 2'd1,
      S_SETTLE = 2'd2
   } state_t;

   state_t          r_state;
   logic [XLEN-1:0] r_target;
   logic            r_trap;

   logic            w_take;
   logic            w_mis;
   logic [XLEN-1:0] w_seq;

   assign w_take = ex_valid & (ex_branch | ex_jump);
   assign w_mis  = (ex_target[1:0] != 2'b00);
   assign w_seq  = pc_cur + XLEN'(4);

   // Outputs are a pure function of state and inputs, forced to 0 in reset.
   always_comb begin
      pc_we         = 1'b0;
      pc_next       = '0;
      flush_ifid    = 1'b0;
      flush_idex    = 1'b0;
      stall_ifid    = 1'b0;
      redirect_busy = 1'b0;
      if (rst_n) begin
         pc_next = w_seq;
         unique case (r_state)
            S_RUN: begin
               if (w_take) begin
                  flush_ifid = 1'b1;
                  flush_idex = 1'b1;
                  if (!w_mis && imem_ready) begin
                     pc_we   = 1'b1;
                     pc_next = ex_target;
                  end
               end else if (load_use_hazard) begin
                  stall_ifid = 1'b1;
                  flush_idex = 1'b1;
               end else if (!imem_ready) begin
                  flush_ifid = 1'b1;
               end else begin
                  pc_we = 1'b1;
               end
            end
            S_PEND: begin
               redirect_busy = 1'b1;
               flush_ifid    = 1'b1;
               flush_idex    = 1'b1;
               pc_next       = r_target;
               pc_we         = imem_ready;
            end
            S_SETTLE: begin
               // The bubble draining from ID must never resolve a branch.
               redirect_busy = 1'b1;
               flush_idex    = 1'b1;
               pc_we         = imem_ready;
               flush_ifid    = ~imem_ready;
            end
            default: begin
               pc_we = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= S_RUN;
         r_target <= '0;
         r_trap   <= 1'b0;
      end else begin
         r_trap <= 1'b0;
         unique case (r_state)
            S_RUN: begin
               if (w_take) begin
                  if (w_mis) begin
                     r_trap <= 1'b1;
                  end else if (imem_ready) begin
                     r_state <= S_SETTLE;
                  end else begin
                     r_target <= ex_target;
                     r_state  <= S_PEND;
                  end
               end
            end
            S_PEND: begin
               if (imem_ready) r_state <= S_SETTLE;
            end
            S_SETTLE: begin
               r_state <= S_RUN;
            end
            default: begin
               r_state <= S_RUN;
            end
         endcase
      end
   end

   assign misalign_trap = r_trap & rst_n;

`ifdef REDIRECT_STATS_EN
   logic [CNT_W-1:0] r_taken_cnt;
   logic [CNT_W-1:0] r_stall_cnt;
   logic             w_redir;

   // A PC write in PEND, or in RUN while taking, carries a redirect target.
   assign w_redir = pc_we &
                    ((r_state == S_PEND) | ((r_state == S_RUN) & w_take));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_taken_cnt <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (w_redir && (r_taken_cnt != '1))
            r_taken_cnt <= r_taken_cnt + CNT_W'(1);
         if (!pc_we && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   assign taken_cnt = rst_n ? r_taken_cnt : '0;
   assign stall_cnt = rst_n ? r_stall_cnt : '0;
`else
   assign taken_cnt = '0;
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench for pc_redirect_ctrl: directed scenarios plus
// randomized traffic against a queue-based behavioural model.

module tb_pc_redirect_ctrl;

   localparam int XLEN  = 32;
   localparam int CNT_W = 16;
`ifdef REDIRECT_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif
   localparam longint SAT = (64'd1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             ex_valid, ex_branch, ex_jump;
   logic [XLEN-1:0]  ex_target;
   logic             load_use_hazard, imem_ready;
   logic [XLEN-1:0]  pc_cur;
   logic             pc_we;
   logic [XLEN-1:0]  pc_next;
   logic             flush_ifid, flush_idex, stall_ifid;
   logic             redirect_busy, misalign_trap;
   logic [CNT_W-1:0] taken_cnt, stall_cnt;

   pc_redirect_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jump(ex_jump),
      .ex_target(ex_target), .load_use_hazard(load_use_hazard),
      .imem_ready(imem_ready), .pc_cur(pc_cur),
      .pc_we(pc_we), .pc_next(pc_next),
      .flush_ifid(flush_ifid), .flush_idex(flush_idex),
      .stall_ifid(stall_ifid), .redirect_busy(redirect_busy),
      .misalign_trap(misalign_trap),
      .taken_cnt(taken_cnt), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // Behavioural model: a queue of redirects waiting for fetch,
   // a "settle cycle owed" flag and a "trap owed" flag.
   logic [XLEN-1:0] pend_q[$];
   bit              settle_owed;
   bit              trap_owed;
   longint          m_taken, m_stall;

   bit              e_we, e_fi, e_fx, e_st, e_busy, e_trap, e_redir;
   logic [XLEN-1:0] e_next;
   logic [CNT_W-1:0] e_tc, e_sc;

   function automatic logic [XLEN-1:0] plus4(input logic [XLEN-1:0] pc);
      return XLEN'((64'(pc) + 64'd4) % (64'd1 << XLEN));
   endfunction

   function automatic void model_eval();
      bit take;
      e_we = 0; e_fi = 0; e_fx = 0; e_st = 0;
      e_busy = 0; e_trap = 0; e_redir = 0; e_next = '0;
      take = ex_valid && (ex_branch || ex_jump);
      if (rst_n) begin
         e_trap = trap_owed;
         if (pend_q.size() > 0) begin
            e_busy = 1; e_fi = 1; e_fx = 1;
            if (imem_ready) begin
               e_we = 1; e_next = pend_q[0]; e_redir = 1;
            end
         end else if (settle_owed) begin
            e_busy = 1; e_fx = 1;
            if (imem_ready) begin e_we = 1; e_next = plus4(pc_cur); end
            else e_fi = 1;
         end else if (take) begin
            e_fi = 1; e_fx = 1;
            if ((ex_target % 4) == 0 && imem_ready) begin
               e_we = 1; e_next = ex_target; e_redir = 1;
            end
         end else if (load_use_hazard) begin
            e_st = 1; e_fx = 1;
         end else if (!imem_ready) begin
            e_fi = 1;
         end else begin
            e_we = 1; e_next = plus4(pc_cur);
         end
      end
      e_tc = (STATS && rst_n) ? CNT_W'(m_taken) : '0;
      e_sc = (STATS && rst_n) ? CNT_W'(m_stall) : '0;
   endfunction

   function automatic void model_commit();
      bit take;
      take = ex_valid && (ex_branch || ex_jump);
      if (!rst_n) begin
         pend_q.delete();
         settle_owed = 0; trap_owed = 0;
         m_taken = 0; m_stall = 0;
      end else begin
         if (e_redir && m_taken < SAT) m_taken++;
         if (!e_we && m_stall < SAT) m_stall++;
         trap_owed = 0;
         if (pend_q.size() > 0) begin
            if (imem_ready) begin
               void'(pend_q.pop_front());
               settle_owed = 1;
            end
         end else if (settle_owed) begin
            settle_owed = 0;
         end else if (take) begin
            if ((ex_target % 4) != 0) trap_owed = 1;
            else if (imem_ready) settle_owed = 1;
            else pend_q.push_back(ex_target);
         end
      end
   endfunction

   // Inputs were applied #1 after an edge; evaluate and let them settle.
   task automatic settle_in();
      model_eval();
      #2;
   endtask

   // Advance one clock; the bench acts as the PC register.
   task automatic step();
      @(posedge clk);
      model_commit();
      #1;
      if (rst_n && e_we) pc_cur = e_next;
   endtask

   task automatic set_ex(input bit v, input bit b, input bit j,
                         input logic [XLEN-1:0] t);
      ex_valid = v; ex_branch = b; ex_jump = j; ex_target = t;
   endtask

   task automatic test_reset();
      rst_n = 0;
      set_ex(1, 1, 1, 32'h0000_0100);
      load_use_hazard = 1; imem_ready = 1; pc_cur = 32'h0;
      for (int i = 0; i < 2; i++) begin
         settle_in();
         n_chk++;
         if ({pc_we, flush_ifid, flush_idex, stall_ifid, redirect_busy,
              misalign_trap} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_ctl%0d: got %b want 000000", i,
                     {pc_we, flush_ifid, flush_idex, stall_ifid,
                      redirect_busy, misalign_trap});
         end
         n_chk++;
         if (pc_next !== '0 || taken_cnt !== '0 || stall_cnt !== '0) begin
            n_err++;
            $display("FAIL reset_data%0d: got %h/%h/%h want 0/0/0", i,
                     pc_next, taken_cnt, stall_cnt);
         end
         step();
      end
      rst_n = 1;
      set_ex(0, 0, 0, '0);
      load_use_hazard = 0;
   endtask

   task automatic test_idle();
      logic [XLEN-1:0] want;
      pc_cur = 32'h0; imem_ready = 1;
      for (int i = 0; i < 4; i++) begin
         want = XLEN'((i + 1) * 4);
         settle_in();
         n_chk++;
         if (pc_we !== 1'b1 || pc_next !== want) begin
            n_err++;
            $display("FAIL idle_pc%0d: got we=%b pc=%h want we=1 pc=%h",
                     i, pc_we, pc_next, want);
         end
         n_chk++;
         if ({flush_ifid, flush_idex, stall_ifid, redirect_busy} !== 4'b0) begin
            n_err++;
            $display("FAIL idle_flush%0d: got %b want 0000", i,
                     {flush_ifid, flush_idex, stall_ifid, redirect_busy});
         end
         step();
      end
   endtask

   task automatic test_beq_taken();
      set_ex(1, 1, 0, 32'h0000_0100);
      imem_ready = 1;
      settle_in();
      n_chk++;
      if ({pc_we, flush_ifid, flush_idex} !== 3'b111 ||
          pc_next !== 32'h100) begin
         n_err++;
         $display("FAIL beq_take: got we/fi/fx=%b pc=%h want 111 pc=100",
                  {pc_we, flush_ifid, flush_idex}, pc_next);
      end
      step();
      // A fresh jump in EX during SETTLE must be ignored.
      set_ex(1, 0, 1, 32'h0000_0300);
      settle_in();
      n_chk++;
      if ({redirect_busy, flush_idex, pc_we} !== 3'b111 ||
          pc_next !== 32'h104) begin
         n_err++;
         $display("FAIL beq_settle: got busy/fx/we=%b pc=%h want 111 pc=104",
                  {redirect_busy, flush_idex, pc_we}, pc_next);
      end
      step();
      set_ex(0, 0, 0, '0);
      settle_in();
      n_chk++;
      if (redirect_busy !== 1'b0 || pc_next !== 32'h108) begin
         n_err++;
         $display("FAIL beq_run: got busy=%b pc=%h want busy=0 pc=108",
                  redirect_busy, pc_next);
      end
      step();
   endtask

   task automatic test_pending();
      set_ex(1, 1, 0, 32'h0000_0200);
      imem_ready = 0;
      for (int i = 0; i < 3; i++) begin
         settle_in();
         n_chk++;
         if ({pc_we, flush_ifid, flush_idex} !== 3'b011) begin
            n_err++;
            $display("FAIL pend_wait%0d: got we/fi/fx=%b want 011", i,
                     {pc_we, flush_ifid, flush_idex});
         end
         step();
         set_ex(1, 0, 1, 32'h0000_0500);
         load_use_hazard = 1;
      end
      imem_ready = 1;
      settle_in();
      n_chk++;
      if ({pc_we, flush_ifid, flush_idex, redirect_busy} !== 4'b1111 ||
          pc_next !== 32'h200) begin
         n_err++;
         $display("FAIL pend_fire: got we/fi/fx/busy=%b pc=%h want 1111 pc=200",
                  {pc_we, flush_ifid, flush_idex, redirect_busy}, pc_next);
      end
      step();
      set_ex(0, 0, 0, '0);
      load_use_hazard = 0;
      settle_in();
      n_chk++;
      if (taken_cnt !== e_tc || stall_cnt !== e_sc) begin
         n_err++;
         $display("FAIL pend_cnt: got taken=%0d stall=%0d want %0d %0d",
                  taken_cnt, stall_cnt, e_tc, e_sc);
      end
      n_chk++;
      if (STATS && (taken_cnt !== CNT_W'(2) || stall_cnt < CNT_W'(3))) begin
         n_err++;
         $display("FAIL pend_cnt_abs: got taken=%0d stall=%0d want 2 >=3",
                  taken_cnt, stall_cnt);
      end
      step();
   endtask

   task automatic test_loaduse();
      set_ex(1, 1, 0, 32'h0000_0040);
      load_use_hazard = 1; imem_ready = 1;
      settle_in();
      n_chk++;
      if (pc_we !== 1'b1 || pc_next !== 32'h40 || stall_ifid !== 1'b0) begin
         n_err++;
         $display("FAIL lu_take: got we=%b pc=%h st=%b want we=1 pc=40 st=0",
                  pc_we, pc_next, stall_ifid);
      end
      step();
      set_ex(0, 0, 0, '0);
      load_use_hazard = 0;
      settle_in();
      step();
      load_use_hazard = 1; imem_ready = 0;
      settle_in();
      n_chk++;
      if ({pc_we, stall_ifid, flush_idex, flush_ifid} !== 4'b0110) begin
         n_err++;
         $display("FAIL lu_alone: got we/st/fx/fi=%b want 0110",
                  {pc_we, stall_ifid, flush_idex, flush_ifid});
      end
      step();
      load_use_hazard = 0; imem_ready = 1;
   endtask

   task automatic test_misalign();
      set_ex(1, 0, 1, 32'h0000_0102);
      imem_ready = 1;
      settle_in();
      n_chk++;
      if ({pc_we, flush_ifid, flush_idex, misalign_trap} !== 4'b0110) begin
         n_err++;
         $display("FAIL mis_take: got we/fi/fx/trap=%b want 0110",
                  {pc_we, flush_ifid, flush_idex, misalign_trap});
      end
      step();
      set_ex(0, 0, 0, '0);
      settle_in();
      n_chk++;
      if (misalign_trap !== 1'b1 || redirect_busy !== 1'b0 || pc_we !== 1'b1) begin
         n_err++;
         $display("FAIL mis_pulse: got trap=%b busy=%b we=%b want 1 0 1",
                  misalign_trap, redirect_busy, pc_we);
      end
      step();
      settle_in();
      n_chk++;
      if (misalign_trap !== 1'b0) begin
         n_err++;
         $display("FAIL mis_once: got trap=%b want 0", misalign_trap);
      end
      step();
   endtask

   task automatic test_wrap();
      pc_cur = 32'hFFFF_FFFC; imem_ready = 1;
      set_ex(0, 0, 0, '0);
      settle_in();
      n_chk++;
      if (pc_we !== 1'b1 || pc_next !== 32'h0) begin
         n_err++;
         $display("FAIL wrap: got we=%b pc=%h want we=1 pc=00000000",
                  pc_we, pc_next);
      end
      step();
   endtask

   task automatic test_reset_in_pend();
      set_ex(1, 1, 0, 32'h0000_0700);
      imem_ready = 0;
      settle_in();
      step();
      set_ex(0, 0, 0, '0);
      settle_in();
      n_chk++;
      if (redirect_busy !== 1'b1) begin
         n_err++;
         $display("FAIL rp_pend: got busy=%b want 1", redirect_busy);
      end
      rst_n = 0; imem_ready = 1;
      settle_in();
      n_chk++;
      if (pc_we !== 1'b0 || redirect_busy !== 1'b0) begin
         n_err++;
         $display("FAIL rp_inrst: got we=%b busy=%b want 0 0",
                  pc_we, redirect_busy);
      end
      step();
      rst_n = 1;
      for (int i = 0; i < 3; i++) begin
         settle_in();
         n_chk++;
         if (redirect_busy !== 1'b0 || pc_we !== 1'b1 ||
             pc_next === 32'h700 || pc_next !== plus4(pc_cur)) begin
            n_err++;
            $display("FAIL rp_after%0d: got busy=%b we=%b pc=%h want 0 1 %h",
                     i, redirect_busy, pc_we, pc_next, plus4(pc_cur));
         end
         n_chk++;
         if (taken_cnt !== '0 || stall_cnt !== '0) begin
            n_err++;
            $display("FAIL rp_cnt%0d: got %0d %0d want 0 0", i,
                     taken_cnt, stall_cnt);
         end
         step();
      end
   endtask

   task automatic test_random();
      logic [XLEN-1:0] t;
      for (int i = 0; i < 400; i++) begin
         rst_n = ($urandom_range(0, 49) != 0);
         t = XLEN'($urandom);
         if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
         set_ex($urandom_range(0, 1) != 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 3) == 0, t);
         load_use_hazard = ($urandom_range(0, 3) == 0);
         imem_ready = ($urandom_range(0, 2) != 0);
         settle_in();
         n_chk++;
         if ({pc_we, flush_ifid, flush_idex, stall_ifid, redirect_busy,
              misalign_trap} !== {e_we, e_fi, e_fx, e_st, e_busy, e_trap}) begin
            n_err++;
            $display("FAIL rnd_ctl%0d: got %b want %b", i,
                     {pc_we, flush_ifid, flush_idex, stall_ifid,
                      redirect_busy, misalign_trap},
                     {e_we, e_fi, e_fx, e_st, e_busy, e_trap});
         end
         if (e_we) begin
            n_chk++;
            if (pc_next !== e_next) begin
               n_err++;
               $display("FAIL rnd_pc%0d: got %h want %h", i, pc_next, e_next);
            end
         end
         n_chk++;
         if (taken_cnt !== e_tc || stall_cnt !== e_sc) begin
            n_err++;
            $display("FAIL rnd_cnt%0d: got %0d/%0d want %0d/%0d", i,
                     taken_cnt, stall_cnt, e_tc, e_sc);
         end
         step();
      end
      rst_n = 1;
   endtask

   initial begin
      pend_q.delete();
      settle_owed = 0; trap_owed = 0;
      m_taken = 0; m_stall = 0;
      test_reset();
      test_idle();
      test_beq_taken();
      test_pending();
      test_loaduse();
      test_misalign();
      test_wrap();
      test_reset_in_pend();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
